// File: rtl/board_support_ctrl.sv
// Board glue between FPGA pins and the SoC: reset stretcher, button debouncers,
// halt toggle, heartbeat and UART activity indicators, and a selectable LED mux.
module board_support_ctrl #(
    parameter int unsigned CLOCK_FREQ        = 50000000,
    parameter int unsigned HEARTBEAT_HZ      = 1,
    parameter int unsigned LEDS_WIDTH        = 8,
    parameter int unsigned BUTTON_COUNT      = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned RESET_HOLD_CYCLES = 1024,
    parameter int unsigned ACTIVITY_CYCLES   = 2500000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [BUTTON_COUNT-1:0] buttons_ni,
    input  logic [1:0]              led_mode_i,
    input  logic [LEDS_WIDTH-1:0]   soc_leds_i,
    input  logic                    uart_rx_i,
    input  logic                    uart_tx_i,
    output logic                    soc_rst_no,
    output logic                    halt_o,
    output logic [BUTTON_COUNT-1:0] buttons_db_o,
    output logic [LEDS_WIDTH-1:0]   led_o
);

    localparam int unsigned HbHalf = CLOCK_FREQ / (2 * HEARTBEAT_HZ);
    localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HoldW  = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam int unsigned HbW    = (HbHalf > 1) ? $clog2(HbHalf) : 1;
    localparam int unsigned ActW   = $clog2(ACTIVITY_CYCLES + 1);

    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD_CYCLES - 1);
    localparam logic [HbW-1:0]   HbLast   = HbW'(HbHalf - 1);
    localparam logic [ActW-1:0]  ActLoad  = ActW'(ACTIVITY_CYCLES);

    typedef enum logic [0:0] {StHold, StRun} state_e;

    // Synchronisers (raw pin level: 1 = released / idle)
    logic [BUTTON_COUNT-1:0] btn_meta_q, btn_sync_q;
    logic                    rx_meta_q, rx_sync_q, rx_prev_q, tx_prev_q;

    // Debouncer state
    logic [BUTTON_COUNT-1:0][DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic [BUTTON_COUNT-1:0]           db_q, db_d;
    logic [1:0]                        db_prev_q;
    logic [BUTTON_COUNT-1:0]           btn_pressed;
    logic                              press0, press1;

    // Indicators
    logic [HbW-1:0]  hb_cnt_q, hb_cnt_d;
    logic            hb_q, hb_d;
    logic [ActW-1:0] rx_act_q, rx_act_d, tx_act_q, tx_act_d;
    logic            rx_fall, tx_fall, rx_active, tx_active;

    // Reset FSM and outputs
    state_e               state_q;
    logic [HoldW-1:0]     hold_cnt_q;
    logic                 soc_rst_n_q, halt_q;
    logic [LEDS_WIDTH-1:0] led_q, led_d;

    assign btn_pressed = ~btn_sync_q;
    assign press0      = db_q[0] & ~db_prev_q[0];
    assign press1      = db_q[1] & ~db_prev_q[1];
    assign rx_fall     = rx_prev_q & ~rx_sync_q;
    // uart_tx already lives in this clock domain, so it is edge-detected directly
    assign tx_fall     = tx_prev_q & ~uart_tx_i;
    assign rx_active   = (rx_act_q != '0);
    assign tx_active   = (tx_act_q != '0);

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_comb begin
        deb_cnt_d = '0;
        db_d      = db_q;
        for (int i = 0; i < int'(BUTTON_COUNT); i++) begin
            if (btn_pressed[i] != db_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    db_d[i] = btn_pressed[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Heartbeat divider and activity stretchers (retriggerable, saturate at zero)
    always_comb begin
        hb_cnt_d = hb_cnt_q + 1'b1;
        hb_d     = hb_q;
        if (hb_cnt_q == HbLast) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end

        rx_act_d = rx_act_q;
        if (rx_fall) begin
            rx_act_d = ActLoad;
        end else if (rx_active) begin
            rx_act_d = rx_act_q - 1'b1;
        end

        tx_act_d = tx_act_q;
        if (tx_fall) begin
            tx_act_d = ActLoad;
        end else if (tx_active) begin
            tx_act_d = tx_act_q - 1'b1;
        end
    end

    // LED source select
    always_comb begin
        led_d = '0;
        unique case (led_mode_i)
            2'd0: led_d = soc_leds_i;
            2'd1: begin
                led_d[0] = hb_q;
                led_d[1] = ~soc_rst_n_q;
                led_d[2] = halt_q;
            end
            2'd2: begin
                led_d[0] = rx_active;
                led_d[1] = tx_active;
            end
            2'd3: led_d = '1;
            default: led_d = '0;
        endcase
    end

    // Datapath registers: synchronisers, debouncers, indicators, LED output
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            btn_meta_q <= '1;
            btn_sync_q <= '1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            tx_prev_q  <= 1'b1;
            deb_cnt_q  <= '0;
            db_q       <= '0;
            db_prev_q  <= '0;
            hb_cnt_q   <= '0;
            hb_q       <= 1'b0;
            rx_act_q   <= '0;
            tx_act_q   <= '0;
            led_q      <= '0;
        end else begin
            btn_meta_q <= buttons_ni;
            btn_sync_q <= btn_meta_q;
            rx_meta_q  <= uart_rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            tx_prev_q  <= uart_tx_i;
            deb_cnt_q  <= deb_cnt_d;
            db_q       <= db_d;
            db_prev_q  <= db_q[1:0];
            hb_cnt_q   <= hb_cnt_d;
            hb_q       <= hb_d;
            rx_act_q   <= rx_act_d;
            tx_act_q   <= tx_act_d;
            led_q      <= led_d;
        end
    end

    // Reset stretcher / halt FSM; soc_rst_n trails the state by one cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StHold;
            hold_cnt_q  <= '0;
            soc_rst_n_q <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            soc_rst_n_q <= (state_q == StRun);
            unique case (state_q)
                StHold: begin
                    halt_q <= 1'b0;
                    if (hold_cnt_q == HoldLast) begin
                        state_q    <= StRun;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    // Soft reset takes priority over a simultaneous halt toggle
                    if (press0) begin
                        state_q    <= StHold;
                        hold_cnt_q <= '0;
                        halt_q     <= 1'b0;
                    end else if (press1) begin
                        halt_q <= ~halt_q;
                    end
                end
                default: begin
                    state_q    <= StHold;
                    hold_cnt_q <= '0;
                end
            endcase
        end
    end

    assign soc_rst_no   = soc_rst_n_q;
    assign halt_o       = halt_q;
    assign buttons_db_o = db_q;
    assign led_o        = led_q;

endmodule
